// File: rtl/demux_rd_perifericos.sv
// Read-return path of the peripheral bus: strobes the selected peripheral's read
// enable, waits for its data (fixed latency or RDY handshake with timeout), returns it with DV.
module demux_rd_perifericos #(
  parameter int          DATA_W    = 32,
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] ERR_VALUE = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        SEL,
  input  logic              RE_procesador,
  input  logic [DATA_W-1:0] DO_ADC_control,
  input  logic [DATA_W-1:0] DO_Teclado,
  input  logic [DATA_W-1:0] DO_siete_segmentos,
  input  logic [DATA_W-1:0] DO_LEDs,
  input  logic [DATA_W-1:0] DO_Switches,
  input  logic [DATA_W-1:0] DO_Timer,
  input  logic              RDY_ADC,
  input  logic              RDY_Teclado,
  output logic              RE_ADC_control,
  output logic              RE_Teclado,
  output logic              RE_siete_segmentos,
  output logic              RE_LEDs,
  output logic              RE_Switches,
  output logic              RE_Timer,
  output logic [DATA_W-1:0] DO_procesador,
  output logic              DV_procesador,
  output logic              ERR_procesador,
  output logic              BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT, ST_DONE} state_t;

  localparam logic [2:0] SEL_ADC  = 3'd0;
  localparam logic [2:0] SEL_TEC  = 3'd2;
  localparam logic [2:0] SEL_7SEG = 3'd3;
  localparam logic [2:0] SEL_LED  = 3'd4;
  localparam logic [2:0] SEL_SW   = 3'd5;
  localparam logic [2:0] SEL_TMR  = 3'd6;

  // Counter value seen on the last allowed WAIT edge (it counts edges already missed).
  localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_VALUE);

  state_t            state, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [7:0]        cnt, cnt_d;
  logic [DATA_W-1:0] do_d;
  logic              err_d;

  logic [DATA_W-1:0] rd_data;
  logic              rd_rdy;
  logic              rd_hs;
  logic              rd_mapped;

  always_comb begin
    rd_data   = '0;
    rd_rdy    = 1'b0;
    rd_hs     = 1'b0;
    rd_mapped = 1'b1;
    case (sel_q)
      SEL_ADC:  begin rd_data = DO_ADC_control; rd_rdy = RDY_ADC;     rd_hs = 1'b1; end
      SEL_TEC:  begin rd_data = DO_Teclado;     rd_rdy = RDY_Teclado; rd_hs = 1'b1; end
      SEL_7SEG: rd_data = DO_siete_segmentos;
      SEL_LED:  rd_data = DO_LEDs;
      SEL_SW:   rd_data = DO_Switches;
      SEL_TMR:  rd_data = DO_Timer;
      default:  rd_mapped = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    cnt_d   = cnt;
    do_d    = DO_procesador;
    err_d   = ERR_procesador;
    case (state)
      ST_IDLE: begin
        if (RE_procesador) begin
          sel_d   = SEL;
          cnt_d   = '0;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!rd_mapped) begin
          do_d    = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (!rd_hs || rd_rdy) begin
          // RDY on the timeout edge still counts as a normal capture.
          do_d    = rd_data;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt == CNT_LAST) begin
          do_d    = ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      sel_q          <= '0;
      cnt            <= '0;
      DO_procesador  <= '0;
      ERR_procesador <= 1'b0;
    end else begin
      state          <= state_d;
      sel_q          <= sel_d;
      cnt            <= cnt_d;
      DO_procesador  <= do_d;
      ERR_procesador <= err_d;
    end
  end

  // Strobes, DV and BUSY decode registered state only, so they are glitch-free one-cycle pulses.
  assign RE_ADC_control     = (state == ST_STROBE) && (sel_q == SEL_ADC);
  assign RE_Teclado         = (state == ST_STROBE) && (sel_q == SEL_TEC);
  assign RE_siete_segmentos = (state == ST_STROBE) && (sel_q == SEL_7SEG);
  assign RE_LEDs            = (state == ST_STROBE) && (sel_q == SEL_LED);
  assign RE_Switches        = (state == ST_STROBE) && (sel_q == SEL_SW);
  assign RE_Timer           = (state == ST_STROBE) && (sel_q == SEL_TMR);
  assign DV_procesador      = (state == ST_DONE);
  assign BUSY               = (state != ST_IDLE);

endmodule

// File: tb/tb_demux_rd_perifericos.sv
// Scoreboard bench for demux_rd_perifericos: reads push {ERR,DATA} expectations,
// a negedge monitor pops and compares them on every DV pulse.
module tb_demux_rd_perifericos;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  SEL;
  logic        RE_procesador;
  logic [31:0] DO_ADC_control, DO_Teclado, DO_siete_segmentos, DO_LEDs, DO_Switches, DO_Timer;
  logic        RDY_ADC, RDY_Teclado;
  logic        RE_ADC_control, RE_Teclado, RE_siete_segmentos, RE_LEDs, RE_Switches, RE_Timer;
  logic [31:0] DO_procesador;
  logic        DV_procesador, ERR_procesador, BUSY;
  logic [5:0]  re_vec;

  int vectors = 0;
  int miscompares = 0;
  int dv_count = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_item;

  demux_rd_perifericos #(.DATA_W(32), .TIMEOUT(16), .ERR_VALUE(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n), .SEL(SEL), .RE_procesador(RE_procesador),
    .DO_ADC_control(DO_ADC_control), .DO_Teclado(DO_Teclado),
    .DO_siete_segmentos(DO_siete_segmentos), .DO_LEDs(DO_LEDs),
    .DO_Switches(DO_Switches), .DO_Timer(DO_Timer),
    .RDY_ADC(RDY_ADC), .RDY_Teclado(RDY_Teclado),
    .RE_ADC_control(RE_ADC_control), .RE_Teclado(RE_Teclado),
    .RE_siete_segmentos(RE_siete_segmentos), .RE_LEDs(RE_LEDs),
    .RE_Switches(RE_Switches), .RE_Timer(RE_Timer),
    .DO_procesador(DO_procesador), .DV_procesador(DV_procesador),
    .ERR_procesador(ERR_procesador), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  // Bit order: ADC, Teclado, siete_segmentos, LEDs, Switches, Timer
  assign re_vec = {RE_ADC_control, RE_Teclado, RE_siete_segmentos, RE_LEDs, RE_Switches, RE_Timer};

  always @(negedge clk) begin
    if (rst_n === 1'b1 && DV_procesador === 1'b1) begin
      dv_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_dv: DO=%h ERR=%b, required no DV", DO_procesador, ERR_procesador);
      end else begin
        exp_item = exp_q.pop_front();
        if ({ERR_procesador, DO_procesador} !== exp_item) begin
          miscompares++;
          $display("FAIL read_data: DO=%h ERR=%b, required DO=%h ERR=%b",
                   DO_procesador, ERR_procesador, exp_item[31:0], exp_item[32]);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; SEL = 3'd0; RE_procesador = 1'b0; RDY_ADC = 1'b0; RDY_Teclado = 1'b0;
    DO_ADC_control = 32'h1111_1111; DO_Teclado = 32'h2222_2222; DO_siete_segmentos = 32'h3333_3333;
    DO_LEDs = 32'h4444_4444; DO_Switches = 32'h5555_5555; DO_Timer = 32'h6666_6666;
    repeat (2) @(negedge clk);
    vectors++;
    if ({DO_procesador, ERR_procesador, DV_procesador, BUSY, re_vec} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: DO=%h ERR=%b DV=%b BUSY=%b RE=%b, required all 0",
               DO_procesador, ERR_procesador, DV_procesador, BUSY, re_vec);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_led_read();
    DO_LEDs = 32'h0000_00A5; SEL = 3'd4; RE_procesador = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_00A5});
    @(negedge clk);
    RE_procesador = 1'b0; SEL = 3'd1;
    vectors++;
    if ({re_vec, BUSY, DV_procesador} !== {6'b000100, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL led_strobe: RE=%b BUSY=%b DV=%b, required RE=000100 BUSY=1 DV=0", re_vec, BUSY, DV_procesador);
    end
    @(negedge clk);
    vectors++;
    if ({re_vec, BUSY, DV_procesador} !== {6'b000000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL led_wait: RE=%b BUSY=%b DV=%b, required RE=0 BUSY=1 DV=0", re_vec, BUSY, DV_procesador);
    end
    @(negedge clk);
    DO_LEDs = 32'hFFFF_0000;
    vectors++;
    if ({re_vec, BUSY, DV_procesador} !== {6'b000000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL led_done: RE=%b BUSY=%b DV=%b, required RE=0 BUSY=1 DV=1", re_vec, BUSY, DV_procesador);
    end
    @(negedge clk);
    vectors++;
    if ({BUSY, DV_procesador, ERR_procesador, DO_procesador} !== {3'b000, 32'h0000_00A5}) begin
      miscompares++;
      $display("FAIL led_after: BUSY=%b DV=%b ERR=%b DO=%h, required 0 0 0 000000a5",
               BUSY, DV_procesador, ERR_procesador, DO_procesador);
    end
  endtask

  task automatic test_adc_handshake();
    DO_ADC_control = 32'h1234_5678; SEL = 3'd0; RE_procesador = 1'b1; RDY_ADC = 1'b0;
    exp_q.push_back({1'b0, 32'h0000_03FF});
    @(negedge clk);
    RE_procesador = 1'b0; RDY_ADC = 1'b1;
    vectors++;
    if (re_vec !== 6'b100000) begin
      miscompares++;
      $display("FAIL adc_strobe: RE=%b, required 100000", re_vec);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      RDY_ADC = 1'b0;
      if (k == 5) begin RDY_ADC = 1'b1; DO_ADC_control = 32'h0000_03FF; end
      vectors++;
      if ({BUSY, DV_procesador, re_vec} !== {2'b10, 6'b000000}) begin
        miscompares++;
        $display("FAIL adc_wait%0d: BUSY=%b DV=%b RE=%b, required BUSY=1 DV=0 RE=0", k, BUSY, DV_procesador, re_vec);
      end
    end
    @(negedge clk);
    RDY_ADC = 1'b0; DO_ADC_control = 32'hBAD0_BAD0;
    vectors++;
    if (DV_procesador !== 1'b1) begin
      miscompares++;
      $display("FAIL adc_dv: DV=%b, required 1", DV_procesador);
    end
    @(negedge clk);
    vectors++;
    if (BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL adc_idle: BUSY=%b, required 0", BUSY);
    end
  endtask

  task automatic test_timeout(input logic rdy_last, input logic [31:0] data);
    SEL = 3'd2; RE_procesador = 1'b1; RDY_Teclado = 1'b0; DO_Teclado = 32'h7777_7777;
    if (rdy_last) exp_q.push_back({1'b0, data});
    else exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    @(negedge clk);
    RE_procesador = 1'b0;
    vectors++;
    if (re_vec !== 6'b010000) begin
      miscompares++;
      $display("FAIL tmo_strobe: RE=%b, required 010000", re_vec);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16 && rdy_last) begin RDY_Teclado = 1'b1; DO_Teclado = data; end
      else DO_Teclado = $urandom;
      vectors++;
      if ({BUSY, DV_procesador} !== 2'b10) begin
        miscompares++;
        $display("FAIL tmo_wait%0d: BUSY=%b DV=%b, required BUSY=1 DV=0", k, BUSY, DV_procesador);
      end
    end
    @(negedge clk);
    RDY_Teclado = 1'b0;
    vectors++;
    if ({BUSY, DV_procesador} !== 2'b11) begin
      miscompares++;
      $display("FAIL tmo_dv: BUSY=%b DV=%b, required BUSY=1 DV=1", BUSY, DV_procesador);
    end
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    SEL = 3'd7; RE_procesador = 1'b1;
    exp_q.push_back({1'b1, 32'h0});
    @(negedge clk);
    RE_procesador = 1'b0;
    vectors++;
    if ({re_vec, BUSY} !== {6'b000000, 1'b1}) begin
      miscompares++;
      $display("FAIL unm_strobe: RE=%b BUSY=%b, required RE=0 BUSY=1", re_vec, BUSY);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (DV_procesador !== 1'b1) begin
      miscompares++;
      $display("FAIL unm_dv: DV=%b, required 1", DV_procesador);
    end
    @(negedge clk);
    vectors++;
    if ({ERR_procesador, BUSY} !== 2'b10) begin
      miscompares++;
      $display("FAIL unm_hold: ERR=%b BUSY=%b, required ERR=1 BUSY=0", ERR_procesador, BUSY);
    end
    SEL = 3'd5; DO_Switches = 32'h0000_5A5A; RE_procesador = 1'b1;
    exp_q.push_back({1'b0, 32'h0000_5A5A});
    @(negedge clk);
    RE_procesador = 1'b0;
    vectors++;
    if ({re_vec, ERR_procesador} !== {6'b000010, 1'b1}) begin
      miscompares++;
      $display("FAIL sw_strobe: RE=%b ERR=%b, required RE=000010 ERR=1", re_vec, ERR_procesador);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({DV_procesador, ERR_procesador} !== 2'b10) begin
      miscompares++;
      $display("FAIL sw_clear: DV=%b ERR=%b, required DV=1 ERR=0", DV_procesador, ERR_procesador);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  s;
    logic [32:0] e;
    logic [5:0]  er;
    RDY_ADC = 1'b1; RDY_Teclado = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s = 3'($urandom_range(7));
      DO_ADC_control = $urandom | 32'h1; DO_Teclado = $urandom | 32'h1;
      DO_siete_segmentos = $urandom | 32'h1; DO_LEDs = $urandom | 32'h1;
      DO_Switches = $urandom | 32'h1; DO_Timer = $urandom | 32'h1;
      case (s)
        3'd0: begin e = {1'b0, DO_ADC_control};     er = 6'b100000; end
        3'd2: begin e = {1'b0, DO_Teclado};         er = 6'b010000; end
        3'd3: begin e = {1'b0, DO_siete_segmentos}; er = 6'b001000; end
        3'd4: begin e = {1'b0, DO_LEDs};            er = 6'b000100; end
        3'd5: begin e = {1'b0, DO_Switches};        er = 6'b000010; end
        3'd6: begin e = {1'b0, DO_Timer};           er = 6'b000001; end
        default: begin e = {1'b1, 32'h0};           er = 6'b000000; end
      endcase
      SEL = s; RE_procesador = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      RE_procesador = 1'b0;
      vectors++;
      if (re_vec !== er) begin
        miscompares++;
        $display("FAIL b2b_strobe sel=%0d: RE=%b, required %b", s, re_vec, er);
      end
      @(negedge clk);
      @(negedge clk);
      DO_LEDs = $urandom; DO_Timer = $urandom; DO_ADC_control = $urandom;
      vectors++;
      if (DV_procesador !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_dv sel=%0d: DV=%b, required 1", s, DV_procesador);
      end
      @(negedge clk);
    end
    RDY_ADC = 1'b0; RDY_Teclado = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int dv0;
    dv0 = dv_count;
    SEL = 3'd0; RE_procesador = 1'b1; RDY_ADC = 1'b0; DO_ADC_control = 32'hCAFE_0001;
    exp_q.push_back({1'b0, 32'hCAFE_0001});
    @(negedge clk);
    RE_procesador = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      SEL = 3'd3; RE_procesador = (k < 4);
      if (k == 4) RDY_ADC = 1'b1;
      vectors++;
      if ({re_vec, BUSY} !== {6'b000000, 1'b1}) begin
        miscompares++;
        $display("FAIL busy_wait%0d: RE=%b BUSY=%b, required RE=0 BUSY=1", k, re_vec, BUSY);
      end
    end
    @(negedge clk);
    RDY_ADC = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({re_vec, BUSY} !== 7'd0) begin
        miscompares++;
        $display("FAIL busy_queued%0d: RE=%b BUSY=%b, required 0", k, re_vec, BUSY);
      end
    end
    vectors++;
    if (dv_count - dv0 !== 1) begin
      miscompares++;
      $display("FAIL busy_dv_count: %0d DV pulses, required 1", dv_count - dv0);
    end
  endtask

  task automatic test_reset_abort();
    int dv0;
    SEL = 3'd0; RE_procesador = 1'b1; RDY_ADC = 1'b0;
    @(negedge clk);
    RE_procesador = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({DO_procesador, ERR_procesador, DV_procesador, BUSY, re_vec} !== 41'd0) begin
      miscompares++;
      $display("FAIL abort_async: DO=%h ERR=%b DV=%b BUSY=%b RE=%b, required all 0",
               DO_procesador, ERR_procesador, DV_procesador, BUSY, re_vec);
    end
    @(negedge clk);
    rst_n = 1'b1; RDY_ADC = 1'b1;
    dv0 = dv_count;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({BUSY, DV_procesador} !== 2'b00) begin
        miscompares++;
        $display("FAIL abort_idle%0d: BUSY=%b DV=%b, required 0 0", k, BUSY, DV_procesador);
      end
    end
    RDY_ADC = 1'b0;
    vectors++;
    if (dv_count !== dv0) begin
      miscompares++;
      $display("FAIL abort_dv: %0d DV pulses after reset, required 0", dv_count - dv0);
    end
  endtask

  initial begin
    test_reset();
    test_led_read();
    test_adc_handshake();
    test_timeout(1'b0, 32'h0);
    test_timeout(1'b1, 32'h0000_0C3A);
    test_unmapped();
    test_back_to_back();
    test_busy_ignore();
    test_reset_abort();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_reads: %0d reads without DV, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_rd_perifericos.md
Name: demux_rd_perifericos

Overview:
Read-return path of the peripheral bus. The processor issues a read with a 3-bit peripheral select. The block strobes the selected peripheral's read enable and waits for that peripheral's data, using a fixed latency or a ready handshake with timeout. It registers the data and returns it to the processor with a one-cycle data-valid pulse. It sits between the processor bus interface and the ADC control, keypad, seven-segment, LED, switch and timer peripherals, using the same SEL address map as the write-enable path.

Parameters:
DATA_W, 32, data width of every peripheral read port and of the processor return bus
TIMEOUT, 16, maximum WAIT cycles for handshake peripherals (ADC, Teclado) before an error return; legal range 2..255
ERR_VALUE, 32'hDEAD_BEEF, value returned on timeout (truncated to DATA_W)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
SEL  in  3  peripheral select: 0 ADC_control, 2 Teclado, 3 siete_segmentos, 4 LEDs, 5 Switches, 6 Timer; 1 and 7 unmapped
RE_procesador  in  1  read request, sampled only in IDLE
DO_ADC_control, DO_Teclado, DO_siete_segmentos, DO_LEDs, DO_Switches, DO_Timer  in  DATA_W each  peripheral read data
RDY_ADC, RDY_Teclado  in  1 each  data-ready from handshake peripherals
RE_ADC_control, RE_Teclado, RE_siete_segmentos, RE_LEDs, RE_Switches, RE_Timer  out  1 each  one-cycle read strobes
DO_procesador  out  DATA_W  registered read data to processor
DV_procesador  out  1  one-cycle data-valid pulse
ERR_procesador  out  1  error flag for the last completed read
BUSY  out  1  high whenever state != IDLE

Behaviour:
- Async reset (rst_n low): state IDLE, sel_q=0, wait counter=0. DO_procesador=0, DV_procesador=0, ERR_procesador=0, all RE_*=0, BUSY=0. Reset mid-transaction aborts it immediately with no DV.
- FSM states: IDLE, STROBE, WAIT, DONE.
- IDLE: at an edge with RE_procesador=1, latch SEL into sel_q, clear the counter and go to STROBE (edge E0). SEL is ignored at every other time.
- STROBE, one cycle (E0–E1): RE_x = (state==STROBE) && (sel_q==x), decoded from registered state only. No strobe is issued for unmapped sel_q. Always go to WAIT.
- WAIT, fixed-latency peripherals (3,4,5,6): at the first WAIT edge (E2), capture DO_x into DO_procesador, set ERR_procesador=0 and go to DONE.
- WAIT, unmapped sel_q (1,7): at E2, DO_procesador=0, ERR_procesador=1, go to DONE.
- WAIT, handshake peripherals (0 ADC, 2 Teclado): RDY is sampled only in WAIT; RDY high during STROBE is ignored.
  - At each WAIT edge with RDY=1: capture DO_x, set ERR=0 and go to DONE.
  - Otherwise the counter increments. At the TIMEOUT-th WAIT edge without RDY: DO_procesador=ERR_VALUE, ERR=1, go to DONE.
  - If RDY=1 on that same edge, RDY wins (normal capture).
- DONE, one cycle: DV_procesador=1, then go to IDLE. For fixed-latency reads DV is high E2–E3. A new request can be accepted at E3 at the earliest.
- DO_procesador and ERR_procesador hold their value until the next capture and are unchanged by IDLE or STROBE.
- RE_procesador during BUSY is ignored and not queued.
- Peripheral data is not required to be stable outside the capture edge.

Test Plan:
- Reset: hold rst_n=0 mid-WAIT of an ADC read -> all outputs 0 asynchronously. After release, state is IDLE and no DV pulse appears.
- LED read: DO_LEDs=32'h0000_00A5, SEL=4, RE pulse at E0 -> RE_LEDs high exactly E0–E1, DV high E2–E3, DO_procesador=32'h0000_00A5, ERR=0, BUSY low after E3.
- ADC handshake: SEL=0, RDY_ADC raised in the 5th WAIT cycle with DO_ADC_control=32'h0000_03FF -> DV one cycle later, data 32'h3FF, ERR=0. RDY held high during STROBE alone does not complete the read.
- Timeout: SEL=2, RDY_Teclado held 0, TIMEOUT=16 -> DV after 16 WAIT cycles, DO_procesador=32'hDEADBEEF, ERR=1. A repeat run with RDY asserted exactly on the 16th WAIT edge returns keypad data, ERR=0.
- Unmapped: SEL=7 -> no RE_* asserted, DV at E2–E3, DO_procesador=0, ERR=1. A following SEL=5 read clears ERR to 0.
- Busy ignore: second RE_procesador with SEL=3 during WAIT of an ADC read -> ignored. Exactly one DV, no RE_siete_segmentos.
